// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM state encoding,
// default framing constants and the running-checksum helper.
package uart_frame_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_SEND    = 3'd4
    } state_e;

    localparam logic [7:0]  SOF_BYTE_DEF    = 8'hA5;
    // Two characters at 9600 baud from a 50 MHz clock.
    localparam logic [16:0] TIMEOUT_MAX_DEF = 17'd104160;

    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: MAX_LEN x 8 registers, one synchronous
// write port and one asynchronous read port.
module uart_frame_buf #(
    parameter  int unsigned MAX_LEN = 16,
    localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic             sys_clk,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [7:0]       wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_data_o
);

    logic [7:0] mem_q [MAX_LEN];

    // Contents need no reset: a frame is only replayed after every slot it uses was written.
    always_ff @(posedge sys_clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/checksum frames from the UART receiver byte stream
// and replays validated payloads on a valid/ready stream with error pulses.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [7:0]  SOF_BYTE    = SOF_BYTE_DEF,
    parameter logic [16:0] TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_data_flag,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic [7:0] frame_len,
    output logic       err_len,
    output logic       err_chk,
    output logic       err_timeout,
    output logic       err_ovr
);

    localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_e      state_q;
    logic [7:0]  len_q;
    logic [7:0]  sum_q;
    logic [7:0]  wr_idx_q;
    logic [7:0]  rd_idx_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q;
    logic        m_last_q;
    logic [16:0] tmo_cnt_q;
    logic [16:0] tmo_cnt_d;
    logic        err_len_q;
    logic        err_chk_q;
    logic        err_timeout_q;
    logic        err_ovr_q;

    logic        wr_en_s;
    logic        hs_s;
    logic        in_frame_s;
    logic        tmo_hit_s;
    logic [7:0]  rd_sel_s;
    logic [7:0]  rd_data_s;

    // Handshake, buffer addressing and inter-byte gap timer next state.
    always_comb begin
        wr_en_s    = (state_q == ST_PAYLOAD) && pi_data_flag;
        hs_s       = m_valid_q && m_ready;
        in_frame_s = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
        tmo_hit_s  = in_frame_s && !pi_data_flag && (tmo_cnt_q == (TIMEOUT_MAX - 17'd1));
        // Read port looks one entry ahead so m_data is already registered when the handshake lands.
        if (state_q == ST_SEND) begin
            rd_sel_s = rd_idx_q + 8'd1;
        end else begin
            rd_sel_s = 8'd0;
        end
        if (in_frame_s && !pi_data_flag && !tmo_hit_s) begin
            tmo_cnt_d = tmo_cnt_q + 17'd1;
        end else begin
            tmo_cnt_d = 17'd0;
        end
    end

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .sys_clk   (sys_clk),
        .wr_en_i   (wr_en_s),
        .wr_idx_i  (wr_idx_q[IDX_W-1:0]),
        .wr_data_i (pi_data),
        .rd_idx_i  (rd_sel_s[IDX_W-1:0]),
        .rd_data_o (rd_data_s)
    );

    // Frame FSM with registered stream outputs and single-cycle error pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            len_q         <= 8'd0;
            sum_q         <= 8'd0;
            wr_idx_q      <= 8'd0;
            rd_idx_q      <= 8'd0;
            m_data_q      <= 8'd0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            tmo_cnt_q     <= 17'd0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovr_q     <= 1'b0;
        end else begin
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovr_q     <= 1'b0;
            tmo_cnt_q     <= tmo_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (pi_data_flag && (pi_data == SOF_BYTE)) begin
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (pi_data_flag) begin
                        if ((pi_data == 8'd0) || (pi_data > MAX_LEN_B)) begin
                            err_len_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            len_q    <= pi_data;
                            sum_q    <= pi_data;
                            wr_idx_q <= 8'd0;
                            state_q  <= ST_PAYLOAD;
                        end
                    end else if (tmo_hit_s) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    if (pi_data_flag) begin
                        sum_q    <= chk_add(sum_q, pi_data);
                        wr_idx_q <= wr_idx_q + 8'd1;
                        if (wr_idx_q == (len_q - 8'd1)) begin
                            state_q <= ST_CHK;
                        end
                    end else if (tmo_hit_s) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_CHK: begin
                    if (pi_data_flag) begin
                        if (pi_data == sum_q) begin
                            rd_idx_q  <= 8'd0;
                            m_valid_q <= 1'b1;
                            m_data_q  <= rd_data_s;
                            m_last_q  <= (len_q == 8'd1);
                            state_q   <= ST_SEND;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end else if (tmo_hit_s) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    // Bytes arriving during replay are dropped, never searched for SOF.
                    err_ovr_q <= pi_data_flag;
                    if (hs_s) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            m_data_q  <= 8'd0;
                            state_q   <= ST_IDLE;
                        end else begin
                            rd_idx_q <= rd_sel_s;
                            m_data_q <= rd_data_s;
                            m_last_q <= (rd_sel_s == (len_q - 8'd1));
                        end
                    end
                end
                default: begin
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frame_len   = len_q;
    assign err_len     = err_len_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_timeout_q;
    assign err_ovr     = err_ovr_q;

endmodule
